// File: rtl/seq_bin2bcd.sv
// Multi-cycle binary-to-BCD converter: one shift-and-add-3 step per clock, optional
// two's-complement sign handling, start/done handshake and a sticky overflow flag.
module seq_bin2bcd #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BW-1:0]     work_q, work_d;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_sign_q, pend_sign_d;
  logic              carry_q, carry_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic              neg_in;

  assign neg_in = (SIGNED != 0) && binary[WIDTH-1];

  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] > 4'd4) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    pend_sign_d = pend_sign_q;
    carry_d     = carry_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SHIFT;
          // Negating the most negative value wraps to 2^(WIDTH-1), which is the right magnitude.
          mag_d       = neg_in ? (~binary + WIDTH'(1)) : binary;
          pend_sign_d = neg_in;
          work_d      = '0;
          carry_d     = 1'b0;
          cnt_d       = CW'(WIDTH);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = {adj[BW-2:0], mag_q[WIDTH-1]};
        mag_d   = {mag_q[WIDTH-2:0], 1'b0};
        carry_d = carry_q | adj[BW-1];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          bcd_d   = work_d;
          sign_d  = pend_sign_q;
          ovf_d   = carry_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      pend_sign_q <= 1'b0;
      carry_q     <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      pend_sign_q <= pend_sign_d;
      carry_q     <= carry_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd      = bcd_q;
  assign sign     = sign_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Bench for seq_bin2bcd: three configurations (12/4/signed, 12/3/unsigned, 8/3/signed)
// driven by one directed sequence with a scoreboard queue per instance.
module tb_seq_bin2bcd;

  typedef struct {
    logic        sign;
    logic        ovf;
    logic [39:0] bcd;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        start_a, start_b, start_c;
  logic [11:0] bin_a, bin_b;
  logic [7:0]  bin_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        sign_a, sign_b, sign_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [15:0] bcd_a;
  logic [11:0] bcd_b, bcd_c;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;
  bit both_seen = 0;
  bit watch = 0;
  bit changed = 0;
  logic [39:0] hold_val = '0;

  seq_bin2bcd #(.WIDTH(12), .DIGITS(4), .SIGNED(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a), .busy(busy_a),
    .done(done_a), .sign(sign_a), .bcd(bcd_a), .overflow(ovf_a));
  seq_bin2bcd #(.WIDTH(12), .DIGITS(3), .SIGNED(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b), .busy(busy_b),
    .done(done_b), .sign(sign_b), .bcd(bcd_b), .overflow(ovf_b));
  seq_bin2bcd #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .binary(bin_c), .busy(busy_c),
    .done(done_c), .sign(sign_c), .bcd(bcd_c), .overflow(ovf_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic done_of(int k);
    case (k)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic busy_of(int k);
    case (k)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic sign_of(int k);
    case (k)
      0: return sign_a;
      1: return sign_b;
      default: return sign_c;
    endcase
  endfunction

  function automatic logic ovf_of(int k);
    case (k)
      0: return ovf_a;
      1: return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic logic [39:0] bcd_of(int k);
    case (k)
      0: return {24'd0, bcd_a};
      1: return {28'd0, bcd_b};
      default: return {28'd0, bcd_c};
    endcase
  endfunction

  // Reference: magnitude by arithmetic, digits by repeated division.
  function automatic exp_t model(int w, int d, bit s, int raw_in);
    exp_t   e;
    longint raw, mag, lim;
    raw = longint'(raw_in) & ((longint'(1) << w) - 1);
    e.sign = s && (((raw >> (w - 1)) & 1) == 1);
    mag = e.sign ? ((longint'(1) << w) - raw) : raw;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    e.ovf = (mag >= lim);
    mag = mag % lim;
    e.bcd = '0;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic st, input int val);
    case (k)
      0: begin start_a = st; bin_a = 12'(val); end
      1: begin start_b = st; bin_b = 12'(val); end
      default: begin start_c = st; bin_c = 8'(val); end
    endcase
  endtask

  task automatic push_exp(input int k, input logic s, input logic o, input logic [39:0] b);
    exp_t e;
    e.sign = s;
    e.ovf  = o;
    e.bcd  = b;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic start_pulse(input int k, input int val);
    drive(k, 1'b1, val);
    tick();
    drive(k, 1'b0, val);
  endtask

  task automatic wait_done(input int k, output int cyc);
    bit   got;
    exp_t e;
    int   qn;
    cyc = 0;
    got = 0;
    while (!got && cyc < 100) begin
      tick();
      cyc++;
      if (busy_of(k) && done_of(k)) both_seen = 1;
      if (done_of(k)) got = 1;
      else if (watch && bcd_of(k) !== hold_val) changed = 1;
    end
    case (k)
      0: qn = q0.size();
      1: qn = q1.size();
      default: qn = q2.size();
    endcase
    if (!got) begin
      chk("done_timeout", 64'(got), 64'd1);
    end else if (qn == 0) begin
      chk("unexpected_done", 64'(qn), 64'd1);
    end else begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("bcd[%0d]", k), 64'(bcd_of(k)), 64'(e.bcd));
      chk($sformatf("sign[%0d]", k), 64'(sign_of(k)), 64'(e.sign));
      chk($sformatf("ovf[%0d]", k), 64'(ovf_of(k)), 64'(e.ovf));
    end
  endtask

  initial begin
    int c;
    int extra;
    rst_n = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    drive(2, 1'b0, 0);
    tick();
    tick();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_bcd", 64'(bcd_a), 64'd0);
    chk("rst_sign", 64'(sign_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    rst_n = 1'b1;
    tick();

    // Signed extremes on the default configuration.
    push_exp(0, 1'b0, 1'b0, 40'h2047);
    start_pulse(0, 'h7FF);
    wait_done(0, c);
    chk("latency_7ff", 64'(c), 64'd12);
    tick();
    chk("done_drop", 64'(done_a), 64'd0);
    push_exp(0, 1'b1, 1'b0, 40'h2048);
    start_pulse(0, 'h800);
    wait_done(0, c);
    push_exp(0, 1'b1, 1'b0, 40'h0001);
    start_pulse(0, 'hFFF);
    wait_done(0, c);

    // Reset in the middle of a conversion aborts it.
    start_pulse(0, 'h7FF);
    tick();
    tick();
    tick();
    chk("mid_busy", 64'(busy_a), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_done", 64'(done_a), 64'd0);
    chk("arst_bcd", 64'(bcd_a), 64'd0);
    chk("arst_sign", 64'(sign_a), 64'd0);
    chk("arst_ovf", 64'(ovf_a), 64'd0);
    tick();
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      tick();
      if (done_a) extra++;
    end
    chk("no_done_after_rst", 64'(extra), 64'd0);
    push_exp(0, 1'b0, 1'b0, 40'h0000);
    start_pulse(0, 0);
    wait_done(0, c);

    // Overflow on 12-bit unsigned with 3 digits.
    push_exp(1, 1'b0, 1'b1, 40'h095);
    start_pulse(1, 4095);
    wait_done(1, c);
    push_exp(1, 1'b0, 1'b0, 40'h999);
    start_pulse(1, 999);
    wait_done(1, c);
    push_exp(1, 1'b0, 1'b1, 40'h000);
    start_pulse(1, 1000);
    wait_done(1, c);

    // Handshake: start during SHIFT is ignored, previous result held.
    push_exp(0, 1'b0, 1'b0, 40'h0999);
    start_pulse(0, 999);
    wait_done(0, c);
    push_exp(0, 1'b0, 1'b0, 40'h0100);
    start_pulse(0, 100);
    hold_val = 40'h0999;
    changed  = 0;
    watch    = 1;
    tick();
    tick();
    drive(0, 1'b1, 200);
    tick();
    drive(0, 1'b0, 200);
    if (bcd_a !== 16'h0999) changed = 1;
    wait_done(0, c);
    watch = 0;
    chk("bcd_stable", 64'(changed), 64'd0);
    extra = 0;
    repeat (30) begin
      tick();
      if (done_a) extra++;
    end
    chk("single_done", 64'(extra), 64'd0);

    // Back-to-back with start held high.
    push_exp(0, 1'b0, 1'b0, 40'h0123);
    drive(0, 1'b1, 123);
    tick();
    drive(0, 1'b1, -456);
    push_exp(0, 1'b1, 1'b0, 40'h0456);
    wait_done(0, c);
    chk("b2b_lat1", 64'(c), 64'd12);
    tick();
    chk("b2b_restart_busy", 64'(busy_a), 64'd1);
    drive(0, 1'b1, 0);
    push_exp(0, 1'b0, 1'b0, 40'h0000);
    wait_done(0, c);
    chk("b2b_gap2", 64'(c + 1), 64'd13);
    tick();
    drive(0, 1'b0, 0);
    wait_done(0, c);
    chk("b2b_gap3", 64'(c + 1), 64'd13);
    chk("busy_and_done", 64'(both_seen), 64'd0);

    // Exhaustive sweep on the 8-bit signed configuration.
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      e = model(8, 3, 1'b1, i);
      push_exp(2, e.sign, e.ovf, e.bcd);
      start_pulse(2, i);
      wait_done(2, c);
    end

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
